// File: rtl/l3_req_arbiter.sv
// Round-robin arbiter serialising NUM_REQ L2 miss ports onto one L3 request port, one transaction in flight.
// Latency: accept T, L3 request T+1, L3 response T+2, resp_valid_o T+3; 1 transaction per 4 cycles at best.
// Backpressure: RESP holds until the winner's resp_ready_i; optional WAIT timeout under L3_ARB_TIMEOUT_EN.
module l3_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    input  logic [NUM_REQ-1:0]        resp_ready_i,
    output logic [DATA_W-1:0]         resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      l3_req_valid_o,
    output logic [ADDR_W-1:0]         l3_req_addr_o,
    output logic                      l3_req_write_o,
    output logic [DATA_W-1:0]         l3_req_wdata_o,
    output logic                      l3_resp_ready_o,
    input  logic                      l3_resp_valid_i,
    input  logic [DATA_W-1:0]         l3_resp_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_vld;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               w_accept;
    logic               w_l3_done;
    logic               w_resp_hs;

`ifdef L3_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [63:0] TMO_PATTERN = 64'hDEAD_DEAD_DEAD_DEAD;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_err;
    logic               w_tmo;
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("l3_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // Scan from the round-robin pointer, wrapping, and take the first valid requester.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        v_idx     = '0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_win_vld && req_valid_i[v_idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = v_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_l3_done   = 1'b0;
        w_resp_hs   = 1'b0;
`ifdef L3_ARB_TIMEOUT_EN
        w_tmo       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (l3_resp_valid_i) begin
                    w_l3_done   = 1'b1;
                    w_state_nxt = S_RESP;
                end
`ifdef L3_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (resp_ready_i[r_grant_idx]) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
`ifdef L3_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_grant_idx <= w_win_idx;
                r_addr      <= req_addr_i[w_win_idx*ADDR_W +: ADDR_W];
                r_write     <= req_write_i[w_win_idx];
                r_wdata     <= req_wdata_i[w_win_idx*DATA_W +: DATA_W];
            end
            if (w_l3_done) begin
                r_rdata <= l3_resp_rdata_i;
            end
            if (w_resp_hs) begin
                r_rr_ptr <= (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
            end
`ifdef L3_ARB_TIMEOUT_EN
            // Counter restarts every time ISSUE hands over to WAIT.
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_l3_done) begin
                r_err <= 1'b0;
            end else if (w_tmo) begin
                r_err   <= 1'b1;
                r_rdata <= DATA_W'(TMO_PATTERN);
            end
`endif
        end
    end

    // Grant is combinational in IDLE and must stay quiet while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (!rst && r_state == S_IDLE && w_win_vld) begin
            req_ready_o[w_win_idx] = 1'b1;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (r_state == S_RESP) begin
            resp_valid_o[r_grant_idx] = 1'b1;
        end
    end

    assign resp_rdata_o    = r_rdata;
    assign l3_req_valid_o  = (r_state == S_ISSUE);
    assign l3_resp_ready_o = (r_state == S_ISSUE);
    assign l3_req_addr_o   = r_addr;
    assign l3_req_write_o  = r_write;
    assign l3_req_wdata_o  = r_wdata;

`ifdef L3_ARB_TIMEOUT_EN
    assign resp_err_o = r_err;
`else
    assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l3_req_arbiter.sv
// Directed bench for l3_req_arbiter with a one-cycle registered L3 memory model.
module tb_l3_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*AW-1:0]   req_addr_i;
    logic [N-1:0]      req_write_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N-1:0]      resp_valid_o;
    logic [N-1:0]      resp_ready_i;
    logic [DW-1:0]     resp_rdata_o;
    logic              resp_err_o;
    logic              l3_req_valid_o;
    logic [AW-1:0]     l3_req_addr_o;
    logic              l3_req_write_o;
    logic [DW-1:0]     l3_req_wdata_o;
    logic              l3_resp_ready_o;
    logic              l3_resp_valid_i;
    logic [DW-1:0]     l3_resp_rdata_i;

    always #5 clk = ~clk;

    l3_req_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .l3_req_valid_o(l3_req_valid_o), .l3_req_addr_o(l3_req_addr_o),
        .l3_req_write_o(l3_req_write_o), .l3_req_wdata_o(l3_req_wdata_o),
        .l3_resp_ready_o(l3_resp_ready_o), .l3_resp_valid_i(l3_resp_valid_i),
        .l3_resp_rdata_i(l3_resp_rdata_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [63:0] rr_val(input int k);
        return 64'hC0DE_0000_0000_00A0 + 64'(k);
    endfunction

    // L3 model: sees the request in ISSUE, answers during the following cycle.
    logic [63:0] mem [logic [63:0]];
    bit          l3_en = 1'b1;

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        bit          w;
        l3_resp_valid_i = 1'b0;
        l3_resp_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rst && l3_req_valid_o && l3_resp_ready_o) begin
                a = l3_req_addr_o;
                w = l3_req_write_o;
                d = l3_req_wdata_o;
                @(posedge clk);
                #1;
                if (l3_en && !rst) begin
                    if (w) begin
                        mem[a] = d;
                        l3_resp_rdata_i = '0;
                    end else begin
                        l3_resp_rdata_i = mem.exists(a) ? mem[a] : 64'h0;
                    end
                    l3_resp_valid_i = 1'b1;
                    @(posedge clk);
                    #1;
                    l3_resp_valid_i = 1'b0;
                    l3_resp_rdata_i = '0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int k, input logic [63:0] a, input bit w, input logic [63:0] d);
        req_addr_i[k*AW +: AW]  = a;
        req_write_i[k]          = w;
        req_wdata_i[k*DW +: DW] = d;
    endtask

    // Lone request from requester k with immediate response acceptance.
    task automatic txn(input string tag, input int k, input logic [63:0] exp_d);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        req_valid_i  = oh;
        resp_ready_i = 4'hF;
        #1;
        chk({tag, "_rdy"}, req_ready_o, oh);
        tick;
        req_valid_i = '0;
        tick;
        tick;
        #1;
        chk({tag, "_vld"}, resp_valid_o, oh);
        chk({tag, "_dat"}, resp_rdata_o, exp_d);
        chk({tag, "_err"}, resp_err_o, 0);
        tick;
    endtask

    initial begin
        int          order [5];
        logic [3:0]  oh;
        logic [63:0] held;
        order = '{0, 1, 2, 3, 0};
        req_valid_i  = '0;
        req_addr_i   = '0;
        req_write_i  = '0;
        req_wdata_i  = '0;
        resp_ready_i = '0;
        mem[64'h100] = 64'hAAAA_5555_0000_1111;
        for (int k = 0; k < N; k++) begin
            mem[64'h200 + 64'(8*k)] = rr_val(k);
            set_req(k, 64'h200 + 64'(8*k), 1'b0, 64'h0);
        end

        // Reset state, with requests pending to show the grant is held off.
        repeat (2) @(posedge clk);
        #2;
        req_valid_i = 4'hF;
        #1;
        chk("rst_rdy", req_ready_o, 0);
        chk("rst_rvld", resp_valid_o, 0);
        chk("rst_l3vld", l3_req_valid_o, 0);
        chk("rst_l3rdy", l3_resp_ready_o, 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_err", resp_err_o, 0);

        // Round robin from rr_ptr=0 with everyone requesting.
        resp_ready_i = 4'hF;
        tick;
        rst = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << order[g];
            chk("rr_grant", req_ready_o, oh);
            tick;
            if (g == 4) req_valid_i = '0;
            #1;
            chk("rr_l3vld", l3_req_valid_o, 1);
            chk("rr_l3addr", l3_req_addr_o, 64'h200 + 64'(8*order[g]));
            tick;
            tick;
            #1;
            chk("rr_rvld", resp_valid_o, oh);
            chk("rr_rdata", resp_rdata_o, rr_val(order[g]));
            tick;
        end

        // Single read from requester 1 with cycle-accurate latency.
        set_req(1, 64'h100, 1'b0, 64'h0);
        req_valid_i  = 4'b0010;
        resp_ready_i = 4'b0010;
        #1;
        chk("sr_rdy", req_ready_o, 4'b0010);
        tick;
        req_valid_i = '0;
        #1;
        chk("sr_l3vld", l3_req_valid_o, 1);
        chk("sr_l3rdy", l3_resp_ready_o, 1);
        chk("sr_l3addr", l3_req_addr_o, 64'h100);
        chk("sr_l3wr", l3_req_write_o, 0);
        tick;
        #1;
        chk("sr_wait_l3vld", l3_req_valid_o, 0);
        chk("sr_wait_rvld", resp_valid_o, 0);
        tick;
        #1;
        chk("sr_rvld", resp_valid_o, 4'b0010);
        chk("sr_rdata", resp_rdata_o, 64'hAAAA_5555_0000_1111);
        chk("sr_err", resp_err_o, 0);
        tick;
        #1;
        chk("sr_idle_rvld", resp_valid_o, 0);

        // Write by requester 2, then read-back by requester 0.
        set_req(2, 64'h40, 1'b1, 64'h1234);
        req_valid_i = 4'b0100;
        #1;
        chk("wr_rdy", req_ready_o, 4'b0100);
        tick;
        req_valid_i = '0;
        #1;
        chk("wr_l3wr", l3_req_write_o, 1);
        chk("wr_l3wdata", l3_req_wdata_o, 64'h1234);
        chk("wr_l3addr", l3_req_addr_o, 64'h40);
        resp_ready_i = 4'hF;
        tick;
        tick;
        #1;
        chk("wr_rvld", resp_valid_o, 4'b0100);
        chk("wr_rdata", resp_rdata_o, 0);
        tick;
        set_req(2, 64'h210, 1'b0, 64'h0);
        set_req(0, 64'h40, 1'b0, 64'h0);
        txn("rd", 0, 64'h1234);

        // Response backpressure on requester 3; requester 0 waits meanwhile.
        req_valid_i = 4'b1000;
        #1;
        chk("bp_rdy", req_ready_o, 4'b1000);
        tick;
        req_valid_i  = 4'b0001;
        resp_ready_i = 4'b0111;
        tick;
        tick;
        #1;
        held = resp_rdata_o;
        chk("bp_rdata0", held, rr_val(3));
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_rvld", resp_valid_o, 4'b1000);
            chk("bp_hold_rdata", resp_rdata_o, rr_val(3));
            chk("bp_hold_rdy", req_ready_o, 0);
            tick;
            #1;
        end
        resp_ready_i = 4'hF;
        #1;
        chk("bp_last_rvld", resp_valid_o, 4'b1000);
        tick;
        #1;
        chk("bp_idle_rvld", resp_valid_o, 0);
        chk("bp_idle_rdy", req_ready_o, 4'b0001);
        tick;
        req_valid_i = '0;
        tick;
        tick;
        #1;
        chk("bp_next_rvld", resp_valid_o, 4'b0001);
        chk("bp_next_rdata", resp_rdata_o, 64'h1234);
        tick;

        // Reset while waiting on the L3; next arbitration restarts at requester 0.
        l3_en = 1'b0;
        req_valid_i = 4'b0100;
        #1;
        chk("mr_rdy", req_ready_o, 4'b0100);
        tick;
        req_valid_i = '0;
        tick;
        #1;
        chk("mr_wait_rvld", resp_valid_o, 0);
        rst = 1'b1;
        #1;
        chk("mr_l3vld", l3_req_valid_o, 0);
        chk("mr_l3addr", l3_req_addr_o, 0);
        chk("mr_rdata", resp_rdata_o, 0);
        req_valid_i = 4'hF;
        #1;
        chk("mr_rdy_in_rst", req_ready_o, 0);
        tick;
        tick;
        rst = 1'b0;
        l3_en = 1'b1;
        #1;
        chk("mr_first", req_ready_o, 4'b0001);
        tick;
        req_valid_i = '0;
        tick;
        tick;
        #1;
        chk("mr_rvld", resp_valid_o, 4'b0001);
        chk("mr_rdata2", resp_rdata_o, 64'h1234);
        tick;

        // L3 that never answers.
        l3_en = 1'b0;
        set_req(1, 64'h100, 1'b0, 64'h0);
        req_valid_i = 4'b0010;
        #1;
        chk("to_rdy", req_ready_o, 4'b0010);
        tick;
        req_valid_i = '0;
        tick;
        #1;
`ifdef L3_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_rvld", resp_valid_o, 0);
            tick;
            #1;
        end
        chk("to_rvld", resp_valid_o, 4'b0010);
        chk("to_rdata", resp_rdata_o, 64'hDEAD_DEAD_DEAD_DEAD);
        chk("to_err", resp_err_o, 1);
        tick;
        #1;
        chk("to_idle_rvld", resp_valid_o, 0);
`else
        for (int i = 0; i < 30; i++) begin
            chk("hang_rvld", resp_valid_o, 0);
            chk("hang_err", resp_err_o, 0);
            tick;
            #1;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
`endif
        l3_en = 1'b1;
        txn("post", 3, rr_val(3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
